// File: rtl/gpr_pkg.sv
// Shared types and default widths for the GPR write-back arbiter slice.
package gpr_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int GPR_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [GPR_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
    } wb_req_t;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        STARVE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/gpr_wb_bypass.sv
// Single read-port forwarding mux: returns the in-flight write data when it targets rs.
module gpr_wb_bypass #(
    parameter int DATA_WIDTH     = 32,
    parameter int GPR_ADDR_WIDTH = 5
) (
    input  logic                      wr_data_en,
    input  logic [GPR_ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [GPR_ADDR_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0]     rs_data_r,
    output logic [DATA_WIDTH-1:0]     rs_fwd
);

    // x0 is never forwarded since it is hardwired to zero in the register file
    always_comb begin
        if (wr_data_en && (rd == rs) && (rs != '0)) begin
            rs_fwd = wr_data;
        end else begin
            rs_fwd = rs_data_r;
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: ALU priority with LSU starvation guard, registered write port.
// Optional rs1/rs2 forwarding enabled by defining GPR_WB_BYPASS_EN.
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int DATA_WIDTH     = gpr_pkg::DATA_WIDTH,
    parameter int GPR_ADDR_WIDTH = gpr_pkg::GPR_ADDR_WIDTH,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      reg_clk,
    input  logic                      reg_rst,
    input  logic                      alu_wb_valid,
    output logic                      alu_wb_ready,
    input  logic [GPR_ADDR_WIDTH-1:0] alu_wb_rd,
    input  logic [DATA_WIDTH-1:0]     alu_wb_data,
    input  logic                      lsu_wb_valid,
    output logic                      lsu_wb_ready,
    input  logic [GPR_ADDR_WIDTH-1:0] lsu_wb_rd,
    input  logic [DATA_WIDTH-1:0]     lsu_wb_data,
    output logic                      wr_data_en,
    output logic [GPR_ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      starve_active
`ifdef GPR_WB_BYPASS_EN
    ,
    input  logic [GPR_ADDR_WIDTH-1:0] rs1,
    input  logic [GPR_ADDR_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0]     rs1_data_r,
    input  logic [DATA_WIDTH-1:0]     rs2_data_r,
    output logic [DATA_WIDTH-1:0]     rs1_fwd,
    output logic [DATA_WIDTH-1:0]     rs2_fwd
`endif
);

    localparam int            CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    arb_state_e    state, state_next;
    logic [CW-1:0] starve_cnt, cnt_next;
    logic          alu_hs, lsu_hs;

    // Grants are mutually exclusive when both requesters are valid
    always_comb begin
        alu_wb_ready = (state == NORMAL) || !lsu_wb_valid;
        lsu_wb_ready = (state == STARVE) || !alu_wb_valid;
        alu_hs       = alu_wb_valid && alu_wb_ready;
        lsu_hs       = lsu_wb_valid && lsu_wb_ready;
    end

    // Next state and starvation counter
    always_comb begin
        state_next = state;
        cnt_next   = starve_cnt;
        case (state)
            NORMAL: begin
                if (lsu_hs || !lsu_wb_valid) begin
                    cnt_next = '0;
                end else if (starve_cnt < LIMIT_C) begin
                    cnt_next = starve_cnt + CW'(1);
                end else begin
                    cnt_next = starve_cnt;
                end
                state_next = (cnt_next == LIMIT_C) ? STARVE : NORMAL;
            end
            STARVE: begin
                cnt_next   = '0;
                state_next = lsu_hs ? NORMAL : STARVE;
            end
            default: begin
                cnt_next   = '0;
                state_next = NORMAL;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= cnt_next;
        end
    end

    // Registered write port; address/data hold when no handshake, x0 writes never enable
    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) begin
            wr_data_en <= 1'b0;
            rd         <= '0;
            wr_data    <= '0;
        end else if (lsu_hs) begin
            wr_data_en <= (lsu_wb_rd != '0);
            rd         <= lsu_wb_rd;
            wr_data    <= lsu_wb_data;
        end else if (alu_hs) begin
            wr_data_en <= (alu_wb_rd != '0);
            rd         <= alu_wb_rd;
            wr_data    <= alu_wb_data;
        end else begin
            wr_data_en <= 1'b0;
        end
    end

    assign starve_active = (state == STARVE);

`ifdef GPR_WB_BYPASS_EN
    gpr_wb_bypass #(
        .DATA_WIDTH     (DATA_WIDTH),
        .GPR_ADDR_WIDTH (GPR_ADDR_WIDTH)
    ) u_bypass_rs1 (
        .wr_data_en (wr_data_en),
        .rd         (rd),
        .wr_data    (wr_data),
        .rs         (rs1),
        .rs_data_r  (rs1_data_r),
        .rs_fwd     (rs1_fwd)
    );

    gpr_wb_bypass #(
        .DATA_WIDTH     (DATA_WIDTH),
        .GPR_ADDR_WIDTH (GPR_ADDR_WIDTH)
    ) u_bypass_rs2 (
        .wr_data_en (wr_data_en),
        .rd         (rd),
        .wr_data    (wr_data),
        .rs         (rs2),
        .rs_data_r  (rs2_data_r),
        .rs_fwd     (rs2_fwd)
    );
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed cases then random traffic vs. a reference model.
module tb_gpr_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int LIMIT = 4;

    logic          reg_clk = 1'b0;
    logic          reg_rst = 1'b1;
    logic          alu_wb_valid = 1'b0, lsu_wb_valid = 1'b0;
    logic          alu_wb_ready, lsu_wb_ready;
    logic [AW-1:0] alu_wb_rd = '0, lsu_wb_rd = '0;
    logic [DW-1:0] alu_wb_data = '0, lsu_wb_data = '0;
    logic          wr_data_en, starve_active;
    logic [AW-1:0] rd;
    logic [DW-1:0] wr_data;
`ifdef GPR_WB_BYPASS_EN
    logic [AW-1:0] rs1 = '0, rs2 = '0;
    logic [DW-1:0] rs1_data_r = '0, rs2_data_r = '0;
    logic [DW-1:0] rs1_fwd, rs2_fwd;
`endif

    gpr_wb_arbiter #(
        .DATA_WIDTH     (DW),
        .GPR_ADDR_WIDTH (AW),
        .STARVE_LIMIT   (LIMIT)
    ) dut (
        .reg_clk       (reg_clk),
        .reg_rst       (reg_rst),
        .alu_wb_valid  (alu_wb_valid),
        .alu_wb_ready  (alu_wb_ready),
        .alu_wb_rd     (alu_wb_rd),
        .alu_wb_data   (alu_wb_data),
        .lsu_wb_valid  (lsu_wb_valid),
        .lsu_wb_ready  (lsu_wb_ready),
        .lsu_wb_rd     (lsu_wb_rd),
        .lsu_wb_data   (lsu_wb_data),
        .wr_data_en    (wr_data_en),
        .rd            (rd),
        .wr_data       (wr_data),
        .starve_active (starve_active)
`ifdef GPR_WB_BYPASS_EN
        ,
        .rs1           (rs1),
        .rs2           (rs2),
        .rs1_data_r    (rs1_data_r),
        .rs2_data_r    (rs2_data_r),
        .rs1_fwd       (rs1_fwd),
        .rs2_fwd       (rs2_fwd)
`endif
    );

    always #5 reg_clk = ~reg_clk;

    int tests = 0;
    int fails = 0;

    // Reference model: cycles LSU has been refused, and whether it is now owed the port
    int            m_wait = 0;
    bit            m_owed = 1'b0;
    bit            e_en   = 1'b0;
    logic [AW-1:0] e_rd   = '0;
    logic [DW-1:0] e_data = '0;
    bit            last_alu_hs = 1'b0, last_lsu_hs = 1'b0;
    int            run_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0;
        m_owed = 1'b0;
        e_en   = 1'b0;
    endtask

    // One clock: check combinational grants, predict, advance, check the write port
    task automatic step();
        bit e_ar, e_lr, lg, ag;
        e_ar = !m_owed || !lsu_wb_valid;
        e_lr = m_owed || !alu_wb_valid;
        #1;
        chk("alu_ready", alu_wb_ready, e_ar);
        chk("lsu_ready", lsu_wb_ready, e_lr);
        chk("starve_active", starve_active, m_owed);
        lg = lsu_wb_valid && e_lr;
        ag = alu_wb_valid && e_ar && !lg;
        if (lg) begin
            e_en = (lsu_wb_rd != 0); e_rd = lsu_wb_rd; e_data = lsu_wb_data;
        end else if (ag) begin
            e_en = (alu_wb_rd != 0); e_rd = alu_wb_rd; e_data = alu_wb_data;
        end else begin
            e_en = 1'b0;
        end
        if (lg || !lsu_wb_valid) begin
            m_wait = 0;
            m_owed = 1'b0;
        end else begin
            if (m_wait < LIMIT) m_wait++;
            if (m_wait == LIMIT) m_owed = 1'b1;
        end
        last_alu_hs = ag;
        last_lsu_hs = lg;
        @(posedge reg_clk);
        #1;
        chk("wr_data_en", wr_data_en, e_en);
        if (e_en) begin
            chk("rd", rd, e_rd);
            chk("wr_data", wr_data, e_data);
        end
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge reg_clk);
        #1;
        chk("reset_en", wr_data_en, 1'b0);
        chk("reset_rd", rd, 0);
        chk("reset_data", wr_data, 0);
        chk("reset_starve", starve_active, 1'b0);
        reg_rst = 1'b0;
        model_reset();

        // ALU-only write
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
        #1 chk("t2_alu_ready", alu_wb_ready, 1'b1);
        step();
        chk("t2_en", wr_data_en, 1'b1);
        chk("t2_rd", rd, 5);
        chk("t2_data", wr_data, 32'hDEADBEEF);

        // Reset while an ALU write is pending; ALU keeps valid and re-arbitrates
        alu_wb_rd = 5'd5; alu_wb_data = 32'h1111;
        #2 reg_rst = 1'b1;
        #1;
        chk("t1_async_en", wr_data_en, 1'b0);
        chk("t1_async_rd", rd, 0);
        @(posedge reg_clk);
        #1;
        chk("t1_en", wr_data_en, 1'b0);
        chk("t1_rd", rd, 0);
        chk("t1_data", wr_data, 0);
        chk("t1_starve", starve_active, 1'b0);
        reg_rst = 1'b0;
        model_reset();
        step();
        chk("t1_rearb_rd", rd, 5);
        alu_wb_valid = 1'b0;
        step();

        // Starvation guard: LSU refused exactly LIMIT cycles, then forced through
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd7; lsu_wb_data = 32'h55;
        alu_wb_valid = 1'b1;
        for (int i = 0; i <= LIMIT; i++) begin
            if (i < LIMIT) begin
                alu_wb_rd = 5'(10 + i); alu_wb_data = 32'(i);
                #1 chk("t3_lsu_blocked", lsu_wb_ready, 1'b0);
            end else begin
                #1;
                chk("t3_starve", starve_active, 1'b1);
                chk("t3_lsu_ready", lsu_wb_ready, 1'b1);
                chk("t3_alu_ready", alu_wb_ready, 1'b0);
            end
            step();
        end
        chk("t3_wr_en", wr_data_en, 1'b1);
        chk("t3_wr_rd", rd, 7);
        chk("t3_wr_data", wr_data, 32'h55);
        lsu_wb_valid = 1'b0;
        alu_wb_valid = 1'b0;
        step();

        // LSU write to x0 is accepted but dropped
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd0; lsu_wb_data = 32'hFFFF;
        #1 chk("t4_lsu_ready", lsu_wb_ready, 1'b1);
        step();
        chk("t4_en", wr_data_en, 1'b0);
        lsu_wb_valid = 1'b0;
        step();

        // Back-to-back ALU writes rd=1..8
        run_len = 0;
        for (int i = 1; i <= 8; i++) begin
            alu_wb_valid = 1'b1; alu_wb_rd = 5'(i); alu_wb_data = 32'(i * 32'h11);
            step();
            if (wr_data_en === 1'b1 && rd === 5'(i)) run_len++;
        end
        chk("t6_run_len", run_len, 8);
        alu_wb_valid = 1'b0;
        step();
        chk("t6_idle_en", wr_data_en, 1'b0);

`ifdef GPR_WB_BYPASS_EN
        // Forwarding of the in-flight write
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd9; alu_wb_data = 32'h1234;
        step();
        alu_wb_valid = 1'b0;
        rs1 = 5'd9; rs2 = 5'd0; rs1_data_r = 32'h5555; rs2_data_r = 32'hAA;
        #1;
        chk("t5_rs1_fwd", rs1_fwd, 32'h1234);
        chk("t5_rs2_fwd", rs2_fwd, 32'hAA);
        step();
        #1 chk("t5_rs1_nofwd", rs1_fwd, 32'h5555);
`endif

        // Random traffic; requesters hold their request until accepted
        last_alu_hs = 1'b0; last_lsu_hs = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!alu_wb_valid || last_alu_hs) begin
                alu_wb_valid = ($urandom_range(0, 3) != 0);
                alu_wb_rd    = 5'($urandom);
                alu_wb_data  = $urandom;
            end
            if (!lsu_wb_valid || last_lsu_hs) begin
                lsu_wb_valid = ($urandom_range(0, 3) != 0);
                lsu_wb_rd    = 5'($urandom);
                lsu_wb_data  = $urandom;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
